// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locking arbiter sharing one UART TX byte path among NREQ requesters
module uart_tx_arbiter #(
  parameter int NREQ = 2,
  parameter int MAX_BURST = 64,
  parameter int STALL_TIMEOUT = 255,
  localparam int GW = NREQ > 1 ? $clog2(NREQ) : 1,
  localparam int BW = MAX_BURST > 0 ? $clog2(MAX_BURST + 1) : 1,
  localparam int SW = STALL_TIMEOUT > 0 ? $clog2(STALL_TIMEOUT + 1) : 1
) (
  input  logic              g_clk,
  input  logic              g_reset,
  output logic              g_clk_req,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic [GW-1:0]     grant_id,
  output logic              busy
);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t r_state;
  logic [GW-1:0] r_grant;
  logic [GW-1:0] r_rr_ptr;
  logic [BW-1:0] r_burst;
  logic [SW-1:0] r_stall;
  logic w_own_valid;
  logic w_hs;
  logic w_burst_end;
  logic w_stall_end;
  logic w_release;
  logic [GW-1:0] w_winner;
  assign busy = r_state == LOCKED;
  assign grant_id = r_grant;
  assign g_clk_req = |req_valid | busy;
  assign w_own_valid = req_valid[r_grant];
  assign tx_valid = busy & w_own_valid;
  assign tx_data = busy ? req_data[8*r_grant +: 8] : 8'h00;
  assign req_ready = busy ? ({{(NREQ-1){1'b0}}, tx_ready} << r_grant) : '0;
  assign w_hs = tx_valid & tx_ready;
  assign w_burst_end = MAX_BURST != 0 && 32'(r_burst) + 1 == MAX_BURST;
  assign w_stall_end = STALL_TIMEOUT != 0 && !w_own_valid && 32'(r_stall) == STALL_TIMEOUT - 1;
  assign w_release = busy & ((w_hs & (req_last[r_grant] | w_burst_end)) | w_stall_end);
  // scan downward so the requester closest after rr_ptr overrides the rest
  always_comb begin
    w_winner = '0;
    for (int k = NREQ; k >= 1; k--)
      if (req_valid[(32'(r_rr_ptr) + k) % NREQ]) w_winner = GW'((32'(r_rr_ptr) + k) % NREQ);
  end
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      r_state <= IDLE;
      r_rr_ptr <= GW'(NREQ - 1);
      r_grant <= '0;
      r_burst <= '0;
      r_stall <= '0;
    end else if (!busy) begin
      if (|req_valid) begin
        r_state <= LOCKED;
        r_grant <= w_winner;
        r_burst <= '0;
        r_stall <= '0;
      end
    end else begin
      r_burst <= r_burst + BW'(w_hs);
      r_stall <= w_own_valid ? '0 : r_stall + SW'(1);
      if (w_release) begin
        r_state <= IDLE;
        r_rr_ptr <= r_grant;
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and randomized bench for uart_tx_arbiter against an in-bench arbitration model
module tb_uart_tx_arbiter;
  localparam int N = 3;
  localparam int MB = 4;
  localparam int ST = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clk_req, tx_valid, busy;
  logic tx_ready = 1'b0;
  logic [N-1:0] req_valid = '0;
  logic [N-1:0] req_last = '0;
  logic [N-1:0] req_ready;
  logic [8*N-1:0] req_data = '0;
  logic [7:0] tx_data;
  logic [1:0] grant_id;
  int checks = 0;
  int errors = 0;
  logic [8:0] qbuf [N][8192];
  int hd [N];
  int tl [N];
  int flush_gen = 0;
  int seen_gen = 0;
  int txr_mode = 1;
  bit gappy = 0;
  logic [N-1:0] hs_n = '0;
  logic [1:0] log_gid [16384];
  logic [7:0] log_dat [16384];
  int nlog = 0;
  int lb = 0;
  int m_own = -1;
  int m_rr = N - 1;
  int m_gid = 0;
  int m_nb = 0;
  int m_st = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NREQ(N), .MAX_BURST(MB), .STALL_TIMEOUT(ST)) dut (
    .g_clk(clk), .g_reset(rst), .g_clk_req(clk_req),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .grant_id(grant_id), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // requesters: each plays its byte queue, holding valid and data until accepted
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (flush_gen != seen_gen) hd[i] = tl[i];
      else if (hs_n[i] && !rst) hd[i]++;
      req_valid[i] = hd[i] < tl[i] && ((req_valid[i] && !(hs_n[i] && !rst)) || !gappy || $urandom_range(0, 2) != 0);
      req_data[8*i +: 8] = hd[i] < tl[i] ? qbuf[i][hd[i]][7:0] : 8'h00;
      req_last[i] = hd[i] < tl[i] && qbuf[i][hd[i]][8];
    end
    seen_gen = flush_gen;
    tx_ready = txr_mode == 2 ? 1'($urandom_range(0, 1)) : txr_mode == 1;
  end

  // reference model: owner (-1 = none), bytes sent and idle-valid cycles in this grant
  always @(posedge clk or posedge rst) begin
    bit v, rel;
    if (rst) begin
      m_own = -1; m_rr = N - 1; m_gid = 0; m_nb = 0; m_st = 0;
    end else if (m_own < 0) begin
      for (int k = 1; k <= N && m_own < 0; k++)
        if (req_valid[(m_rr + k) % N]) m_own = (m_rr + k) % N;
      if (m_own >= 0) begin m_gid = m_own; m_nb = 0; m_st = 0; end
    end else begin
      v = req_valid[m_own];
      m_nb += (v && tx_ready) ? 1 : 0;
      m_st = v ? 0 : m_st + 1;
      rel = (v && tx_ready && (req_last[m_own] || m_nb == MB)) || m_st == ST;
      if (rel) begin m_rr = m_own; m_own = -1; end
    end
  end

  always @(negedge clk) begin
    bit b;
    int g;
    b = m_own >= 0;
    g = b ? m_own : 0;
    hs_n = req_valid & req_ready;
    chk("busy", 32'(busy), 32'(b));
    chk("tx_valid", 32'(tx_valid), 32'(b && req_valid[g]));
    chk("tx_data", 32'(tx_data), b ? 32'(req_data[8*g +: 8]) : 32'd0);
    chk("req_ready", 32'(req_ready), (b && tx_ready) ? (32'd1 << g) : 32'd0);
    chk("grant_id", 32'(grant_id), 32'(m_gid));
    chk("clk_req", 32'(clk_req), 32'(|req_valid || b));
    if (tx_valid === 1'b1 && tx_ready && nlog < 16384) begin
      log_gid[nlog] = grant_id;
      log_dat[nlog] = tx_data;
      nlog++;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input int i, input logic [7:0] d, input logic l);
    if (tl[i] < 8000) begin
      qbuf[i][tl[i]] = {l, d};
      tl[i]++;
    end
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1;
    flush_gen++;
    @(posedge clk);
    #3;
    rst = 1'b0;
    lb = nlog;
  endtask

  function automatic bit idle_now();
    idle_now = busy === 1'b0 && req_valid == '0;
    for (int i = 0; i < N; i++) if (hd[i] != tl[i]) idle_now = 0;
  endfunction

  task automatic wait_idle(input int max, input string name);
    int n = 0;
    while (n < max && !idle_now()) begin step(); n++; end
    if (!idle_now()) begin
      checks++;
      errors++;
      $display("FAIL %s: arbiter not idle after %0d cycles, required idle", name, max);
    end
  endtask

  initial begin
    int t2_g[9] = '{0, 0, 0, 1, 1, 1, 0, 0, 0};
    int t2_d[9] = '{8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22, 8'h30, 8'h31, 8'h32};
    int t3_g[13] = '{0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0};
    int t3_d[13] = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h60, 8'h61, 8'h62, 8'h54, 8'h55, 8'h56, 8'h57, 8'h58, 8'h59};
    int n;
    // single byte from requester 0, plus clock request behaviour
    do_reset();
    step();
    chk("t6_clk_req_idle", clk_req, 0);
    chk("t1_reset_grant_id", grant_id, 0);
    chk("t1_reset_tx_data", tx_data, 0);
    push(0, 8'h41, 1'b1);
    step();
    chk("t6_clk_req_on_valid", clk_req, 1);
    chk("t1_idle_tx_valid", tx_valid, 0);
    chk("t1_idle_busy", busy, 0);
    step();
    chk("t1_tx_valid", tx_valid, 1);
    chk("t1_tx_data", tx_data, 8'h41);
    chk("t1_req_ready", req_ready, 3'b001);
    chk("t1_busy", busy, 1);
    step();
    chk("t1_release_busy", busy, 0);
    chk("t1_release_tx_valid", tx_valid, 0);
    // round-robin between two 3-byte packet streams
    do_reset();
    for (int b = 0; b < 3; b++) push(0, 8'(8'h10 + b), b == 2);
    for (int b = 0; b < 3; b++) push(1, 8'(8'h20 + b), b == 2);
    for (int b = 0; b < 3; b++) push(0, 8'(8'h30 + b), b == 2);
    wait_idle(100, "t2_drain");
    chk("t2_count", nlog - lb, 9);
    for (int j = 0; j < 9; j++) begin
      chk($sformatf("t2_owner_%0d", j), log_gid[lb + j], t2_g[j]);
      chk($sformatf("t2_data_%0d", j), log_dat[lb + j], t2_d[j]);
    end
    // burst limit hands over mid-stream, then stall releases the tail
    do_reset();
    for (int b = 0; b < 10; b++) push(0, 8'(8'h50 + b), 1'b0);
    for (int b = 0; b < 3; b++) push(1, 8'(8'h60 + b), b == 2);
    wait_idle(150, "t3_drain");
    chk("t3_count", nlog - lb, 13);
    for (int j = 0; j < 13; j++) begin
      chk($sformatf("t3_owner_%0d", j), log_gid[lb + j], t3_g[j]);
      chk($sformatf("t3_data_%0d", j), log_dat[lb + j], t3_d[j]);
    end
    // stall timeout after one byte, and back-pressure never releases
    do_reset();
    push(0, 8'h70, 1'b0);
    n = 0;
    while (nlog - lb < 1 && n < 20) begin step(); n++; end
    chk("t4_first_byte", nlog - lb, 1);
    n = 0;
    while (n < 40) begin
      step();
      if (busy !== 1'b1) break;
      n++;
    end
    chk("t4_stall_cycles", n, ST);
    txr_mode = 0;
    push(0, 8'h71, 1'b1);
    repeat (100) step();
    chk("t4_bp_busy", busy, 1);
    chk("t4_bp_tx_valid", tx_valid, 1);
    chk("t4_bp_tx_data", tx_data, 8'h71);
    txr_mode = 1;
    wait_idle(20, "t4_drain");
    chk("t4_bp_byte_sent", log_dat[nlog - 1], 8'h71);
    // asynchronous reset mid-byte, then pointer restarts at requester 0
    do_reset();
    txr_mode = 0;
    push(0, 8'h80, 1'b0);
    push(0, 8'h81, 1'b1);
    push(1, 8'h90, 1'b1);
    push(2, 8'hA0, 1'b1);
    repeat (3) step();
    chk("t5_pre_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("t5_rst_tx_valid", tx_valid, 0);
    chk("t5_rst_req_ready", req_ready, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_grant_id", grant_id, 0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    lb = nlog;
    txr_mode = 1;
    wait_idle(100, "t5_drain");
    chk("t5_count", nlog - lb, 4);
    chk("t5_first_owner", log_gid[lb], 0);
    chk("t5_first_data", log_dat[lb], 8'h80);
    chk("t5_third_owner", log_gid[lb + 2], 1);
    chk("t5_fourth_owner", log_gid[lb + 3], 2);
    // randomized traffic with gaps, random back-pressure and occasional resets
    do_reset();
    gappy = 1;
    txr_mode = 2;
    repeat (4000) begin
      step();
      for (int i = 0; i < N; i++)
        if (tl[i] - hd[i] < 4 && $urandom_range(0, 3) == 0) push(i, 8'($urandom), $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 799) == 0) begin
        rst = 1'b1;
        @(posedge clk);
        #3;
        rst = 1'b0;
      end
    end
    gappy = 0;
    txr_mode = 1;
    wait_idle(3000, "rand_drain");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
